// File: rtl/seg7_scan_display.sv
// Four-digit common-anode hex display scanner with a shadow register loaded on the falling edge of iUpdate.
// Optional decimal-point support is enabled by defining SEG7_DP_EN.
module seg7_scan_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        iClk,
  input  logic        inReset,
  input  logic [15:0] iData,
  input  logic        iUpdate,
  input  logic        iLzb,
`ifdef SEG7_DP_EN
  input  logic [3:0]  iDp,
  output logic        oDp,
`endif
  output logic [6:0]  oSeg,
  output logic [3:0]  oAn,
  output logic        oFrame
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    digit;
  logic [15:0]   shadow;
  logic          upd_prev;
  logic          scan_tick;
  logic          capture;
  logic          blank;
  logic [3:0]    nibble;
  logic [6:0]    seg_next;

  assign scan_tick = (prescaler == LAST);
  assign capture   = upd_prev & ~iUpdate;
  assign nibble    = shadow[{digit, 2'b00} +: 4];

  // A digit is blanked only when it and every more significant nibble are zero.
  always_comb begin
    blank = 1'b0;
    case (digit)
      2'd3:    blank = (shadow[15:12] == 4'h0);
      2'd2:    blank = (shadow[15:8] == 8'h00);
      2'd1:    blank = (shadow[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
    blank = blank & iLzb;
  end

  always_comb begin
    seg_next = 7'b1111111;
    case (nibble)
      4'h0: seg_next = 7'b1000000;
      4'h1: seg_next = 7'b1111001;
      4'h2: seg_next = 7'b0100100;
      4'h3: seg_next = 7'b0110000;
      4'h4: seg_next = 7'b0011001;
      4'h5: seg_next = 7'b0010010;
      4'h6: seg_next = 7'b0000010;
      4'h7: seg_next = 7'b1111000;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0010000;
      4'hA: seg_next = 7'b0001000;
      4'hB: seg_next = 7'b0000011;
      4'hC: seg_next = 7'b1000110;
      4'hD: seg_next = 7'b0100001;
      4'hE: seg_next = 7'b0000110;
      4'hF: seg_next = 7'b0001110;
      default: seg_next = 7'b1111111;
    endcase
  end

  // Outputs are built from the pre-edge index and shadow, so a capture that lands
  // on a scan advance appears on the new digit one cycle later.
  always_ff @(posedge iClk) begin
    if (!inReset) begin
      prescaler <= '0;
      digit     <= 2'd0;
      shadow    <= 16'h0000;
      upd_prev  <= 1'b0;
      oSeg      <= 7'b1111111;
      oAn       <= 4'b1111;
      oFrame    <= 1'b0;
    end else begin
      upd_prev  <= iUpdate;
      if (capture) shadow <= iData;
      prescaler <= scan_tick ? '0 : prescaler + 1'b1;
      if (scan_tick) digit <= digit + 2'd1;
      oFrame    <= scan_tick && (digit == 2'd3);
      oAn       <= ~(4'b0001 << digit);
      oSeg      <= blank ? 7'b1111111 : seg_next;
    end
  end

`ifdef SEG7_DP_EN
  logic [3:0] dp_shadow;

  // The decimal point is never blanked.
  always_ff @(posedge iClk) begin
    if (!inReset) begin
      dp_shadow <= 4'h0;
      oDp       <= 1'b1;
    end else begin
      if (capture) dp_shadow <= iDp;
      oDp <= ~dp_shadow[digit];
    end
  end
`endif

endmodule
